display_scanner: RTL and testbench

Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It holds a displayed value and sequences one digit at a time through a hex-to-7-segment decoder (display_driver, active-low seg[7:0], bit7 = dp, bits6..0 = gfedcba). It inserts anti-ghosting blank gaps between digits. A load handshake updates the displayed value atomically at frame boundaries. It sits between keyboard/FSM logic and the board's segment and anode pins.

---
 rtl/display_scanner.sv | 156 +++++++++++++++
 tb/tb_display_scanner.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/display_scanner.sv
// Time-multiplexed scan controller for a common-anode 7-segment display.
// Scans one digit per slot with a dark gap at slot start; new values apply only at frame boundaries.
module display_scanner #(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 1024,
  parameter int BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [4*N_DIGITS-1:0] number,
  input  logic [N_DIGITS-1:0]   dots,
  input  logic [N_DIGITS-1:0]   digit_en,
  input  logic                  lzs,
  input  logic                  load,
  output logic                  pending,
  output logic [7:0]            abcdefgh,
  output logic [N_DIGITS-1:0]   digit,
  output logic                  frame_tick
);

  localparam int CW = $clog2(PRESCALE);
  localparam int SW = $clog2(N_DIGITS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_CYCLES);
  localparam logic [SW-1:0] SLOT_LAST = SW'(N_DIGITS - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t                state;
  logic [CW-1:0]         cnt, cnt_next;
  logic [SW-1:0]         slot, slot_next;
  logic                  end_of_slot, boundary;

  logic [4*N_DIGITS-1:0] shadow_num, act_num;
  logic [N_DIGITS-1:0]   shadow_dots, act_dots;
  logic [N_DIGITS-1:0]   shadow_en, act_en;
  logic                  shadow_lzs, act_lzs;

  logic [N_DIGITS-1:0]   sup;
  logic                  upper_zero;
  logic [3:0]            cur_nib;
  logic                  cur_dot, cur_en, cur_sup;
  logic [6:0]            seg7;
  logic [N_DIGITS-1:0]   digit_next;

  always_comb begin
    end_of_slot = (cnt == CNT_LAST);
    boundary    = end_of_slot && (slot == SLOT_LAST);
    cnt_next    = end_of_slot ? '0 : cnt + CW'(1);
    slot_next   = slot;
    if (end_of_slot)
      slot_next = (slot == SLOT_LAST) ? '0 : slot + SW'(1);
  end

  // A digit above 0 is blank when it and every more significant nibble are zero.
  always_comb begin
    sup        = '0;
    upper_zero = 1'b1;
    for (int i = N_DIGITS - 1; i > 0; i--) begin
      upper_zero = upper_zero & (act_num[4*i +: 4] == 4'h0);
      sup[i]     = act_lzs & upper_zero;
    end
  end

  always_comb begin
    cur_nib = 4'h0;
    cur_dot = 1'b0;
    cur_en  = 1'b0;
    cur_sup = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (slot == SW'(i)) begin
        cur_nib = act_num[4*i +: 4];
        cur_dot = act_dots[i];
        cur_en  = act_en[i];
        cur_sup = sup[i];
      end
    end
    digit_next = '1;
    for (int i = 0; i < N_DIGITS; i++)
      digit_next[i] = !((state == SHOW) && cur_en && (slot == SW'(i)));
  end

  always_comb begin
    case (cur_nib)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  end

  // State, shadow/active handshake and registered pin drive; the shadow seen before a
  // boundary edge is what gets applied, so a load in that same cycle waits a frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= BLANK;
      cnt         <= '0;
      slot        <= '0;
      frame_tick  <= 1'b0;
      pending     <= 1'b0;
      shadow_num  <= '0;
      shadow_dots <= '0;
      shadow_en   <= '0;
      shadow_lzs  <= 1'b0;
      act_num     <= '0;
      act_dots    <= '0;
      act_en      <= '0;
      act_lzs     <= 1'b0;
      digit       <= '1;
      abcdefgh    <= 8'hFF;
    end else begin
      cnt        <= cnt_next;
      slot       <= slot_next;
      state      <= (cnt_next < BLANK_END) ? BLANK : SHOW;
      frame_tick <= (cnt_next == CNT_LAST) && (slot_next == SLOT_LAST);

      if (load) begin
        shadow_num  <= number;
        shadow_dots <= dots;
        shadow_en   <= digit_en;
        shadow_lzs  <= lzs;
      end

      if (boundary) begin
        if (pending) begin
          act_num  <= shadow_num;
          act_dots <= shadow_dots;
          act_en   <= shadow_en;
          act_lzs  <= shadow_lzs;
        end
        pending <= load;
      end else if (load) begin
        pending <= 1'b1;
      end

      digit <= digit_next;
      if ((state == SHOW) && cur_en)
        abcdefgh <= {~cur_dot, cur_sup ? 7'h7F : seg7};
      else
        abcdefgh <= 8'hFF;
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Bench for display_scanner (4 digits, 8 cycles/slot, 2 blank cycles).
// Stimulus queues the expected lit-digit runs; a negedge monitor pops and compares them.
module tb_display_scanner;

  logic        clk;
  logic        reset;
  logic [15:0] number;
  logic [3:0]  dots;
  logic [3:0]  digit_en;
  logic        lzs;
  logic        load;
  logic        pending;
  logic [7:0]  abcdefgh;
  logic [3:0]  digit;
  logic        frame_tick;

  typedef struct {
    logic [3:0] dig;
    logic [7:0] seg;
    int         len;
  } rec_t;

  rec_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  int   cyc = 0;
  bit   in_run = 0;
  int   run_len = 0;
  int   run_len_exp = 0;
  logic [3:0] run_dig;
  logic [7:0] run_seg;

  display_scanner #(
    .N_DIGITS(4),
    .PRESCALE(8),
    .BLANK_CYCLES(2)
  ) dut (
    .clk(clk),
    .reset(reset),
    .number(number),
    .dots(dots),
    .digit_en(digit_en),
    .lzs(lzs),
    .load(load),
    .pending(pending),
    .abcdefgh(abcdefgh),
    .digit(digit),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp)
      passes++;
    else
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input logic [15:0] num, input logic [3:0] dp,
                               input logic [3:0] en, input logic lz);
    number   = num;
    dots     = dp;
    digit_en = en;
    lzs      = lz;
    load     = 1'b1;
    @(posedge clk);
    #1 load = 1'b0;
  endtask

  task automatic pushRec(input logic [3:0] dig, input logic [7:0] seg, input int len);
    rec_t r;
    r.dig = dig;
    r.seg = seg;
    r.len = len;
    exp_q.push_back(r);
  endtask

  task automatic waitTick();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (frame_tick) break;
    end
    checkOutput("frame_tick_seen", {31'd0, frame_tick}, 32'd1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Per-cycle rules plus the start, stability and length of every lit-digit run.
  always @(negedge clk) begin
    if (reset) begin
      cyc    = 0;
      in_run = 0;
    end else begin
      checkOutput("frame_tick", {31'd0, frame_tick}, {31'd0, (cyc % 32) == 31});
      checkOutput("onehot_anode", {31'd0, $countones(~digit) <= 1}, 32'd1);
      if (digit == 4'hF) begin
        checkOutput("dark_segments", {24'd0, abcdefgh}, 32'hFF);
        if (in_run && run_len_exp != 0)
          checkOutput("run_length", run_len, run_len_exp);
        in_run = 0;
      end else if (!in_run) begin
        run_len_exp = 0;
        if (exp_q.size() == 0) begin
          checkOutput("unexpected_lit", {28'd0, digit}, 32'hF);
        end else begin
          rec_t r;
          r = exp_q.pop_front();
          checkOutput("digit", {28'd0, digit}, {28'd0, r.dig});
          checkOutput("segments", {24'd0, abcdefgh}, {24'd0, r.seg});
          run_len_exp = r.len;
        end
        in_run  = 1;
        run_len = 1;
        run_dig = digit;
        run_seg = abcdefgh;
      end else begin
        checkOutput("run_stable", {20'd0, digit, abcdefgh}, {20'd0, run_dig, run_seg});
        run_len++;
      end
      cyc++;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    load     = 1'b0;
    number   = '0;
    dots     = '0;
    digit_en = '0;
    lzs      = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    @(negedge clk);
    checkOutput("reset_digit", {28'd0, digit}, 32'hF);
    checkOutput("reset_segments", {24'd0, abcdefgh}, 32'hFF);
    checkOutput("reset_pending", {31'd0, pending}, 32'd0);
    checkOutput("reset_tick", {31'd0, frame_tick}, 32'd0);
    waitTick();
    waitTick();

    $display("[TB] load 12AF with dp on digit 2");
    idle(5);
    applyStimulus(16'h12AF, 4'b0100, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("pending_after_load", {31'd0, pending}, 32'd1);
    pushRec(4'b1110, 8'h8E, 6);
    pushRec(4'b1101, 8'h88, 6);
    pushRec(4'b1011, 8'h24, 6);
    pushRec(4'b0111, 8'hF9, 6);
    waitTick();
    checkOutput("pending_at_boundary", {31'd0, pending}, 32'd1);
    @(negedge clk);
    checkOutput("pending_after_boundary", {31'd0, pending}, 32'd0);

    $display("[TB] leading-zero suppression");
    idle(4);
    applyStimulus(16'h0050, 4'b0000, 4'hF, 1'b1);
    pushRec(4'b1110, 8'hC0, 6);
    pushRec(4'b1101, 8'h92, 6);
    pushRec(4'b1011, 8'hFF, 6);
    pushRec(4'b0111, 8'hFF, 6);
    waitTick();
    idle(5);
    applyStimulus(16'h0000, 4'b0000, 4'hF, 1'b1);
    pushRec(4'b1110, 8'hC0, 6);
    pushRec(4'b1101, 8'hFF, 6);
    pushRec(4'b1011, 8'hFF, 6);
    pushRec(4'b0111, 8'hFF, 6);
    waitTick();

    $display("[TB] loads A and B in one frame, C in the boundary cycle");
    idle(3);
    applyStimulus(16'h3333, 4'b0000, 4'hF, 1'b0);
    idle(5);
    applyStimulus(16'h2222, 4'b0000, 4'hF, 1'b0);
    pushRec(4'b1110, 8'hA4, 6);
    pushRec(4'b1101, 8'hA4, 6);
    pushRec(4'b1011, 8'hA4, 6);
    pushRec(4'b0111, 8'hA4, 6);
    waitTick();
    applyStimulus(16'h7654, 4'b0000, 4'hF, 1'b0);
    pushRec(4'b1110, 8'h99, 6);
    pushRec(4'b1101, 8'h92, 6);
    pushRec(4'b1011, 8'h82, 6);
    pushRec(4'b0111, 8'hF8, 6);
    @(negedge clk);
    checkOutput("pending_boundary_load", {31'd0, pending}, 32'd1);
    waitTick();
    checkOutput("pending_before_c", {31'd0, pending}, 32'd1);
    @(negedge clk);
    checkOutput("pending_after_c", {31'd0, pending}, 32'd0);

    $display("[TB] digit_en 0101");
    idle(4);
    applyStimulus(16'h89CD, 4'b0000, 4'b0101, 1'b0);
    pushRec(4'b1110, 8'hA1, 6);
    pushRec(4'b1011, 8'h90, 0);
    waitTick();

    $display("[TB] reset mid-SHOW of slot 2 with a load pending");
    idle(2);
    applyStimulus(16'hBEEF, 4'hF, 4'hF, 1'b0);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (digit == 4'b1011) break;
    end
    checkOutput("slot2_lit_seen", {28'd0, digit}, 32'hB);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    checkOutput("pending_before_reset", {31'd0, pending}, 32'd1);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkOutput("pending_after_reset", {31'd0, pending}, 32'd0);
    checkOutput("tick_after_reset", {31'd0, frame_tick}, 32'd0);
    @(negedge clk);
    checkOutput("digit_after_reset", {28'd0, digit}, 32'hF);
    checkOutput("segments_after_reset", {24'd0, abcdefgh}, 32'hFF);
    waitTick();
    waitTick();

    $display("[TB] fresh load after reset");
    idle(3);
    applyStimulus(16'h0003, 4'b0001, 4'b0001, 1'b1);
    pushRec(4'b1110, 8'h30, 6);
    waitTick();
    checkOutput("pending_final", {31'd0, pending}, 32'd1);
    @(negedge clk);
    checkOutput("pending_final_applied", {31'd0, pending}, 32'd0);
    waitTick();
    checkOutput("queue_drained", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
